// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared state encodings and default widths for game_sequencer
package game_sequencer_pkg;

    localparam logic [2:0] ST_ATTRACT   = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_DYING     = 3'd3;
    localparam logic [2:0] ST_OVER      = 3'd4;

    localparam int GS_SCREEN_HEIGHT = 480;
    localparam int GS_CEILING_Y     = GS_SCREEN_HEIGHT;
    localparam int GS_SCORE_W       = 10;
    localparam int GS_Y_W           = 11;

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - 2-FF synchronizer with one-tick rising-edge pulse for a raw button
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = s2_q & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - flappy-bird game-flow FSM; GAME_SEQ_BOUNDS_KILL_EN adds floor/ceiling kill
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int COUNTDOWN_TICKS = 96,
    parameter int DEATH_TICKS     = 64,
    parameter int FLASH_SHIFT     = 3,
    parameter int SCORE_W         = GS_SCORE_W,
    parameter int Y_W             = GS_Y_W,
    parameter int CEILING_Y       = GS_CEILING_Y
) (
    input  logic               gameClk,
    input  logic               reset,
    input  logic               button,
    input  logic               hitColumn,
    input  logic               passColumn,
    input  logic [SCORE_W-1:0] score,
    input  logic [Y_W-1:0]     bird_y,
    output logic               run,
    output logic               finished,
    output logic               world_reset,
    output logic               flap,
    output logic               flash,
    output logic [SCORE_W-1:0] best_score,
    output logic [2:0]         state
);

    localparam int CNT_MAX = (COUNTDOWN_TICKS > DEATH_TICKS) ? COUNTDOWN_TICKS : DEATH_TICKS;
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CD_LOAD    = CNT_W'(COUNTDOWN_TICKS - 1);
    localparam logic [CNT_W-1:0] DEATH_LOAD = CNT_W'(DEATH_TICKS - 1);
    localparam int FL_W = (FLASH_SHIFT < 1) ? 1 : FLASH_SHIFT;
    localparam logic [FL_W-1:0] FLASH_LAST = FL_W'((1 << FLASH_SHIFT) - 1);

    logic               click;
    logic               kill;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FL_W-1:0]    fcnt_q, fcnt_d;
    logic               run_q, run_d;
    logic               finished_q, finished_d;
    logic               world_reset_q, world_reset_d;
    logic               flap_q, flap_d;
    logic               flash_q, flash_d;
    logic [SCORE_W-1:0] best_q, best_d;

    btn_edge_sync u_btn (
        .clk   (gameClk),
        .rst_n (reset),
        .din   (button),
        .pulse (click)
    );

`ifdef GAME_SEQ_BOUNDS_KILL_EN
    localparam logic [Y_W-1:0] CEIL = Y_W'(CEILING_Y);
    logic unused_inputs;
    assign unused_inputs = passColumn;
    assign kill = hitColumn | (bird_y == '0) | (bird_y >= CEIL);
`else
    logic unused_inputs;
    assign unused_inputs = ^{passColumn, bird_y};
    assign kill = hitColumn;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fcnt_d        = fcnt_q;
        flash_d       = flash_q;
        best_d        = best_q;
        world_reset_d = 1'b0;
        flap_d        = 1'b0;

        // the blink phase runs continuously from DYING entry through OVER
        if (state_q == ST_DYING || state_q == ST_OVER) begin
            if (fcnt_q == FLASH_LAST) begin
                fcnt_d  = '0;
                flash_d = ~flash_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_ATTRACT: begin
                if (click) begin
                    state_d       = ST_COUNTDOWN;
                    cnt_d         = CD_LOAD;
                    world_reset_d = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (cnt_q == '0) state_d = ST_PLAY;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_PLAY: begin
                if (kill) begin
                    state_d = ST_DYING;
                    cnt_d   = DEATH_LOAD;
                    fcnt_d  = '0;
                    flash_d = 1'b1;
                    if (score > best_q) best_d = score;
                end else begin
                    flap_d = click;
                end
            end
            ST_DYING: begin
                if (cnt_q == '0) state_d = ST_OVER;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_OVER: begin
                if (click) begin
                    state_d       = ST_ATTRACT;
                    world_reset_d = 1'b1;
                    fcnt_d        = '0;
                    flash_d       = 1'b0;
                end
            end
            default: begin
                state_d = ST_ATTRACT;
                flash_d = 1'b0;
            end
        endcase

        run_d      = (state_d == ST_PLAY);
        finished_d = (state_d == ST_DYING) || (state_d == ST_OVER);
    end

    always_ff @(posedge gameClk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_ATTRACT;
            cnt_q         <= '0;
            fcnt_q        <= '0;
            run_q         <= 1'b0;
            finished_q    <= 1'b0;
            world_reset_q <= 1'b0;
            flap_q        <= 1'b0;
            flash_q       <= 1'b0;
            best_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fcnt_q        <= fcnt_d;
            run_q         <= run_d;
            finished_q    <= finished_d;
            world_reset_q <= world_reset_d;
            flap_q        <= flap_d;
            flash_q       <= flash_d;
            best_q        <= best_d;
        end
    end

    assign state       = state_q;
    assign run         = run_q;
    assign finished    = finished_q;
    assign world_reset = world_reset_q;
    assign flap        = flap_q;
    assign flash       = flash_q;
    assign best_score  = best_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized self-checking bench for game_sequencer
module tb_game_sequencer;

    localparam int SW = 10;
    localparam int YW = 11;
    localparam int CD = 4;
    localparam int DT = 8;
    localparam int FS = 3;

    logic          gameClk = 1'b0;
    logic          reset = 1'b0;
    logic          button = 1'b0;
    logic          hitColumn = 1'b0;
    logic          passColumn = 1'b0;
    logic [SW-1:0] score = '0;
    logic [YW-1:0] bird_y = 11'd200;
    logic          run, finished, world_reset, flap, flash;
    logic [SW-1:0] best_score;
    logic [2:0]    state;

    int n_cmp = 0;
    int n_err = 0;
    int best_model = 0;

    game_sequencer #(
        .COUNTDOWN_TICKS (CD),
        .DEATH_TICKS     (DT),
        .FLASH_SHIFT     (FS)
    ) dut (
        .gameClk     (gameClk),
        .reset       (reset),
        .button      (button),
        .hitColumn   (hitColumn),
        .passColumn  (passColumn),
        .score       (score),
        .bird_y      (bird_y),
        .run         (run),
        .finished    (finished),
        .world_reset (world_reset),
        .flap        (flap),
        .flash       (flash),
        .best_score  (best_score),
        .state       (state)
    );

    always #5 gameClk = ~gameClk;

    task automatic tick();
        @(posedge gameClk);
        #1;
    endtask

    // presses the button from ATTRACT and waits (bounded) until PLAY
    task automatic start_game();
        button = 1'b1;
        repeat (3) tick();
        button = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (state == 3'd2) break;
            tick();
        end
        n_cmp++;
        if (state !== 3'd2) begin
            n_err++;
            $display("FAIL start_game: state=%0d want 2 (timeout)", state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if ({state, run, finished, world_reset, flap, flash, best_score} !== '0) begin
                n_err++;
                $display("FAIL reset_idle t=%0d: st=%0d run=%b fin=%b wr=%b flap=%b flash=%b best=%0d want all 0",
                         i, state, run, finished, world_reset, flap, flash, best_score);
            end
        end
    endtask

    task automatic test_countdown();
        button = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) button = 1'b0;
            tick();
            // press lands on the 3rd edge; then CD ticks of countdown, then PLAY
            n_cmp++;
            if (world_reset !== (c == 2)) begin
                n_err++;
                $display("FAIL cd_world_reset c=%0d: got %b want %b", c, world_reset, (c == 2));
            end
            n_cmp++;
            if (state !== ((c < 2) ? 3'd0 : (c < 2 + CD) ? 3'd1 : 3'd2)) begin
                n_err++;
                $display("FAIL cd_state c=%0d: got %0d", c, state);
            end
            n_cmp++;
            if (run !== (c >= 2 + CD)) begin
                n_err++;
                $display("FAIL cd_run c=%0d: got %b want %b", c, run, (c >= 2 + CD));
            end
        end
    endtask

    task automatic test_flap();
        bit sched[64];
        int pos;
        int flaps;
        bit exp_f;
        for (int i = 0; i < 64; i++) sched[i] = 1'b0;
        pos = 2;
        for (int p = 0; p < 3; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) sched[pos + j] = 1'b1;
            pos += len + $urandom_range(4, 8);
        end
        flaps = 0;
        for (int c = 0; c < 64; c++) begin
            button = sched[c];
            passColumn = 1'($urandom_range(0, 1));
            tick();
            exp_f = (c >= 2) && sched[c-2] && !((c >= 3) && sched[c-3]);
            if (flap) flaps++;
            n_cmp++;
            if (flap !== exp_f) begin
                n_err++;
                $display("FAIL flap_timing c=%0d: got %b want %b", c, flap, exp_f);
            end
        end
        passColumn = 1'b0;
        n_cmp++;
        if (flaps !== 3) begin
            n_err++;
            $display("FAIL flap_count: got %0d want 3", flaps);
        end
    endtask

    task automatic test_hold();
        int flaps;
        flaps = 0;
        button = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (c == 20) button = 1'b0;
            tick();
            if (flap) flaps++;
        end
        n_cmp++;
        if (flaps !== 1) begin
            n_err++;
            $display("FAIL hold_flap_count: got %0d want 1", flaps);
        end
    endtask

    task automatic test_death(input int sc);
        score = SW'(sc);
        if (sc > best_model) best_model = sc;
        button = 1'b1;
        tick();
        tick();
        hitColumn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) begin
                hitColumn = 1'b0;
                n_cmp++;
                if (flap !== 1'b0) begin
                    n_err++;
                    $display("FAIL death_no_flap: got %b want 0", flap);
                end
                n_cmp++;
                if (best_score !== SW'(best_model)) begin
                    n_err++;
                    $display("FAIL death_best: got %0d want %0d", best_score, best_model);
                end
            end
            if (k == 2) button = 1'b0;
            n_cmp++;
            if ({state, finished, run} !== {((k < DT) ? 3'd3 : 3'd4), 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL death_state k=%0d: st=%0d fin=%b run=%b", k, state, finished, run);
            end
            n_cmp++;
            if (flash !== (((k >> FS) & 1) == 0)) begin
                n_err++;
                $display("FAIL death_flash k=%0d: got %b want %b", k, flash, (((k >> FS) & 1) == 0));
            end
        end
    endtask

    task automatic test_over_exit();
        button = 1'b1;
        repeat (3) tick();
        button = 1'b0;
        n_cmp++;
        if ({state, world_reset, flash, finished} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL over_exit: st=%0d wr=%b flash=%b fin=%b want 0 1 0 0",
                     state, world_reset, flash, finished);
        end
        tick();
        n_cmp++;
        if (world_reset !== 1'b0) begin
            n_err++;
            $display("FAIL over_exit_pulse: wr=%b want 0", world_reset);
        end
        repeat (4) tick();
    endtask

    task automatic test_second_game(input int sc);
        start_game();
        score = SW'(sc);
        if (sc > best_model) best_model = sc;
        repeat ($urandom_range(0, 5)) tick();
        hitColumn = 1'b1;
        tick();
        hitColumn = 1'b0;
        for (int k = 1; k < 32; k++) begin
            if (k == 3) button = 1'b1;
            tick();
        end
        n_cmp++;
        if ({state, best_score} !== {3'd4, SW'(best_model)}) begin
            n_err++;
            $display("FAIL held_over: st=%0d best=%0d want 4 %0d", state, best_score, best_model);
        end
        button = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (state !== 3'd4) begin
            n_err++;
            $display("FAIL release_over: st=%0d want 4", state);
        end
        button = 1'b1;
        repeat (3) tick();
        button = 1'b0;
        n_cmp++;
        if ({state, world_reset} !== {3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL repress_exit: st=%0d wr=%b want 0 1", state, world_reset);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_midgame();
        start_game();
        repeat (3) tick();
        #3;
        reset = 1'b0;
        #1;
        best_model = 0;
        n_cmp++;
        if ({state, run, best_score} !== {3'd0, 1'b0, SW'(0)}) begin
            n_err++;
            $display("FAIL async_reset: st=%0d run=%b best=%0d want 0 0 0", state, run, best_score);
        end
        tick();
        reset = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_bounds();
        start_game();
        bird_y = '0;
        tick();
        bird_y = 11'd200;
`ifdef GAME_SEQ_BOUNDS_KILL_EN
        n_cmp++;
        if (state !== 3'd3) begin
            n_err++;
            $display("FAIL bounds_kill: st=%0d want 3", state);
        end
`else
        n_cmp++;
        if (state !== 3'd2) begin
            n_err++;
            $display("FAIL bounds_ignored: st=%0d want 2", state);
        end
`endif
        repeat (3) tick();
    endtask

    initial begin
        int s1, s2;
        s1 = $urandom_range(5, 900);
        s2 = $urandom_range(0, s1 - 1);
        test_reset();
        test_countdown();
        repeat (3) tick();
        test_flap();
        test_hold();
        test_death(s1);
        test_over_exit();
        test_second_game(s2);
        test_reset_midgame();
        test_bounds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
